// File: rtl/uart_frame_ctrl.sv
// Frame parser behind the 16x UART receiver: SYNC/ADDR/DATA/CHK frames
// write the VU-meter level and control registers; errors and stalls abort a frame.
module uart_frame_ctrl #(
    parameter logic [7:0]  SYNC_BYTE = 8'hA5,
    parameter int unsigned TIMEOUT   = 640,
    parameter logic [7:0]  CTRL_RST  = 8'h01
) (
    input  logic       clkx16,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_load,
    input  logic       rx_error,
    output logic       rx_clr,
    output logic [7:0] level_l,
    output logic [7:0] level_r,
    output logic [7:0] ctrl,
    output logic       frame_ok,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {
        S_SYNC,
        S_ADDR,
        S_DATA,
        S_CHK,
        S_RECOVER
    } state_t;

    // Compared against the pre-increment count so expiry lands on the edge
    // where the count would reach TIMEOUT-1.
    localparam logic [15:0] EXPIRE_AT = 16'(TIMEOUT - 2);

    state_t      r_state, w_state_nxt;
    logic [15:0] r_cnt, w_cnt_nxt;
    logic [1:0]  r_addr, w_addr_nxt;
    logic [7:0]  r_data, w_data_nxt;
    logic        w_ok, w_err, w_clr;

    always_comb begin
        w_state_nxt = r_state;
        w_addr_nxt  = r_addr;
        w_data_nxt  = r_data;
        w_ok        = 1'b0;
        w_err       = 1'b0;
        w_clr       = 1'b0;

        if (r_state == S_RECOVER) begin
            if (!rx_error) begin
                w_state_nxt = S_SYNC;
            end
        end else if (rx_error) begin
            w_state_nxt = S_RECOVER;
            w_err       = 1'b1;
            w_clr       = 1'b1;
        end else if (rx_load) begin
            case (r_state)
                S_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_state_nxt = S_ADDR;
                    end
                end
                S_ADDR: begin
                    if (rx_data <= 8'd2) begin
                        w_addr_nxt  = rx_data[1:0];
                        w_state_nxt = S_DATA;
                    end else if (rx_data != SYNC_BYTE) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_SYNC;
                    end
                end
                S_DATA: begin
                    w_data_nxt  = rx_data;
                    w_state_nxt = S_CHK;
                end
                S_CHK: begin
                    if (rx_data == ({6'b0, r_addr} ^ r_data)) begin
                        w_ok = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                    w_state_nxt = S_SYNC;
                end
                default: w_state_nxt = S_SYNC;
            endcase
        end else if (r_state != S_SYNC && r_cnt == EXPIRE_AT) begin
            w_err       = 1'b1;
            w_state_nxt = S_SYNC;
        end

        if (rx_load || w_state_nxt == S_SYNC || w_state_nxt == S_RECOVER) begin
            w_cnt_nxt = '0;
        end else begin
            w_cnt_nxt = r_cnt + 16'd1;
        end
    end

    always_ff @(posedge clkx16 or posedge reset) begin
        if (reset) begin
            r_state   <= S_SYNC;
            r_cnt     <= '0;
            r_addr    <= '0;
            r_data    <= '0;
            rx_clr    <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            level_l   <= '0;
            level_r   <= '0;
            ctrl      <= CTRL_RST;
            err_cnt   <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_addr    <= w_addr_nxt;
            r_data    <= w_data_nxt;
            rx_clr    <= w_clr;
            frame_ok  <= w_ok;
            frame_err <= w_err;
            if (w_ok) begin
                case (r_addr)
                    2'd0:    level_l <= r_data;
                    2'd1:    level_r <= r_data;
                    2'd2:    ctrl    <= r_data;
                    default: ;
                endcase
            end
            if (w_err && err_cnt != 8'hFF) begin
                err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_ctrl.sv
// Scoreboard bench for uart_frame_ctrl: a byte-list frame model predicts
// every frame_ok/frame_err/rx_clr event; a monitor checks them as they appear.
module tb_uart_frame_ctrl;

    localparam logic [7:0] SYNC = 8'hA5;
    localparam int         TO   = 640;
    localparam logic [7:0] CRST = 8'h01;

    logic       clkx16 = 1'b0;
    logic       reset  = 1'b1;
    logic [7:0] rx_data = '0;
    logic       rx_load = 1'b0;
    logic       rx_error = 1'b0;
    logic       rx_clr, frame_ok, frame_err;
    logic [7:0] level_l, level_r, ctrl, err_cnt;

    uart_frame_ctrl #(
        .SYNC_BYTE(SYNC),
        .TIMEOUT  (TO),
        .CTRL_RST (CRST)
    ) dut (
        .clkx16   (clkx16),
        .reset    (reset),
        .rx_data  (rx_data),
        .rx_load  (rx_load),
        .rx_error (rx_error),
        .rx_clr   (rx_clr),
        .level_l  (level_l),
        .level_r  (level_r),
        .ctrl     (ctrl),
        .frame_ok (frame_ok),
        .frame_err(frame_err),
        .err_cnt  (err_cnt)
    );

    always #5 clkx16 = ~clkx16;

    int cyc = 0;
    always @(posedge clkx16) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         ok;
        bit         clr;
        logic [7:0] l, r, c, e;
    } ev_t;

    ev_t        exp_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    // Reference model: bytes of the frame collected so far, idle count, registers.
    logic [7:0] frm[$];
    bit         m_rec = 1'b0;
    int         m_idle = 0;
    logic [7:0] m_l = '0, m_r = '0, m_c = CRST, m_e = '0;

    task automatic emit(input bit ok, input bit clr);
        ev_t ev;
        if (!ok && m_e != 8'hFF) m_e++;
        ev.cyc = cyc + 1;
        ev.ok  = ok;
        ev.clr = clr;
        ev.l   = m_l;
        ev.r   = m_r;
        ev.c   = m_c;
        ev.e   = m_e;
        exp_q.push_back(ev);
    endtask

    task automatic model_step(input bit ld, input logic [7:0] d, input bit er);
        if (m_rec) begin
            if (!er) m_rec = 1'b0;
            return;
        end
        if (er) begin
            m_rec = 1'b1;
            frm.delete();
            m_idle = 0;
            emit(1'b0, 1'b1);
            return;
        end
        if (ld) begin
            m_idle = 0;
            case (frm.size())
                0: if (d == SYNC) frm.push_back(d);
                1: begin
                    if (d <= 8'd2) frm.push_back(d);
                    else if (d != SYNC) begin
                        frm.delete();
                        emit(1'b0, 1'b0);
                    end
                end
                2: frm.push_back(d);
                default: begin
                    if (d == (frm[1] ^ frm[2])) begin
                        case (frm[1])
                            8'd0:    m_l = frm[2];
                            8'd1:    m_r = frm[2];
                            default: m_c = frm[2];
                        endcase
                        emit(1'b1, 1'b0);
                    end else begin
                        emit(1'b0, 1'b0);
                    end
                    frm.delete();
                end
            endcase
        end else if (frm.size() > 0) begin
            m_idle++;
            if (m_idle == TO - 1) begin
                frm.delete();
                m_idle = 0;
                emit(1'b0, 1'b0);
            end
        end
    endtask

    task automatic model_reset();
        frm.delete();
        m_rec  = 1'b0;
        m_idle = 0;
        m_l = '0; m_r = '0; m_c = CRST; m_e = '0;
    endtask

    // Monitor: every DUT event pops one expectation; an expectation whose cycle
    // passes without a DUT event is reported as missing.
    always @(negedge clkx16) begin
        if (!reset) begin
            if (frame_ok || frame_err || rx_clr) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_event cyc=%0d ok=%0b err=%0b clr=%0b", cyc, frame_ok, frame_err, rx_clr);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    if (ev.cyc != cyc || frame_ok != ev.ok || frame_err != !ev.ok || rx_clr != ev.clr ||
                        level_l != ev.l || level_r != ev.r || ctrl != ev.c || err_cnt != ev.e) begin
                        n_bad++;
                        $display("FAIL event got cyc=%0d ok=%0b err=%0b clr=%0b l=%h r=%h c=%h e=%h exp cyc=%0d ok=%0b err=%0b clr=%0b l=%h r=%h c=%h e=%h",
                                 cyc, frame_ok, frame_err, rx_clr, level_l, level_r, ctrl, err_cnt,
                                 ev.cyc, ev.ok, !ev.ok, ev.clr, ev.l, ev.r, ev.c, ev.e);
                    end
                end
            end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL missing_event at cyc=%0d expected ok=%0b clr=%0b", exp_q[0].cyc, exp_q[0].ok, exp_q[0].clr);
                void'(exp_q.pop_front());
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic drive(input bit ld, input logic [7:0] d, input bit er);
        @(negedge clkx16);
        rx_load  = ld;
        rx_data  = d;
        rx_error = er;
        model_step(ld, d, er);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 8'($urandom), 1'b0);
    endtask

    task automatic send(input logic [7:0] b);
        drive(1'b1, b, 1'b0);
        idle($urandom_range(0, 2));
    endtask

    task automatic check_regs(input string tag);
        check({tag, "_level_l"}, int'(level_l), int'(m_l));
        check({tag, "_level_r"}, int'(level_r), int'(m_r));
        check({tag, "_ctrl"},    int'(ctrl),    int'(m_c));
        check({tag, "_err_cnt"}, int'(err_cnt), int'(m_e));
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_level_l"},   int'(level_l),   0);
        check({tag, "_level_r"},   int'(level_r),   0);
        check({tag, "_ctrl"},      int'(ctrl),      int'(CRST));
        check({tag, "_err_cnt"},   int'(err_cnt),   0);
        check({tag, "_frame_ok"},  int'(frame_ok),  0);
        check({tag, "_frame_err"}, int'(frame_err), 0);
        check({tag, "_rx_clr"},    int'(rx_clr),    0);
    endtask

    task automatic do_reset();
        drive(1'b0, 8'h00, 1'b0);
        @(posedge clkx16);
        #2;
        reset = 1'b1;
        model_reset();
        @(negedge clkx16);
        check_reset_state("midreset");
        check("midreset_queue", exp_q.size(), 0);
        reset = 1'b0;
        model_step(1'b0, rx_data, 1'b0);
    endtask

    initial begin
        logic [7:0] a8, d8, b8;

        repeat (3) @(negedge clkx16);
        check_reset_state("por");
        reset = 1'b0;
        model_step(1'b0, 8'h00, 1'b0);

        // Good frame to level_l
        send(SYNC); send(8'h00); send(8'h3C); send(8'h3C);
        idle(2);
        check_regs("good");

        // Bad checksum, then the corrected frame
        send(SYNC); send(8'h01); send(8'h55); send(8'h00);
        idle(2);
        check_regs("badchk");
        send(SYNC); send(8'h01); send(8'h55); send(8'h54);
        idle(2);
        check_regs("fixchk");

        // Resync on repeated SYNC, then an invalid address
        send(SYNC); send(SYNC); send(8'h02); send(8'hF3); send(8'hF1);
        idle(2);
        check_regs("resync");
        send(SYNC); send(8'h07);
        idle(2);
        check_regs("badaddr");

        // Timeout after ADDR with exactly TO-1 idle cycles, then recovery
        drive(1'b1, SYNC, 1'b0);
        drive(1'b1, 8'h00, 1'b0);
        idle(TO - 1);
        idle(2);
        check_regs("timeout");
        send(SYNC); send(8'h00); send(8'h11); send(8'h11);
        idle(2);
        check_regs("post_timeout");

        // Receiver error with a simultaneous byte
        send(SYNC); send(8'h02);
        drive(1'b1, 8'h33, 1'b1);
        repeat (3) drive(1'b0, 8'h00, 1'b1);
        drive(1'b0, 8'h00, 1'b0);
        send(SYNC); send(8'h02); send(8'h00); send(8'h02);
        idle(2);
        check_regs("rxerr");

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            a8 = 8'($urandom_range(0, 2));
            d8 = 8'($urandom);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: begin
                    send(SYNC); send(a8); send(d8); send(a8 ^ d8);
                end
                4: begin
                    send(SYNC); send(a8); send(d8);
                    send((a8 ^ d8) ^ 8'($urandom_range(1, 255)));
                end
                5: begin
                    b8 = 8'($urandom_range(3, 255));
                    if (b8 == SYNC) b8 = 8'h07;
                    send(SYNC); send(b8);
                end
                6: begin
                    send(SYNC); send(SYNC); send(a8); send(d8); send(a8 ^ d8);
                end
                7: send(8'($urandom));
                8: begin
                    send(SYNC);
                    if ($urandom_range(0, 1) == 1) send(a8);
                    drive(1'($urandom_range(0, 1)), d8, 1'b1);
                    repeat ($urandom_range(0, 4)) drive(1'($urandom_range(0, 1)), 8'($urandom), 1'b1);
                    drive(1'b0, 8'h00, 1'b0);
                end
                default: begin
                    drive(1'b1, SYNC, 1'b0);
                    drive(1'b1, a8, 1'b0);
                    idle($urandom_range(TO - 4, TO));
                    send(d8); send(a8 ^ d8);
                end
            endcase
        end
        idle(3);
        check_regs("random");

        // Error counter saturation
        for (int i = 0; i < 256; i++) begin
            drive(1'b1, SYNC, 1'b0);
            drive(1'b1, 8'h07, 1'b0);
        end
        idle(2);
        check("sat_err_cnt", int'(err_cnt), 8'hFF);
        check_regs("sat");

        // Reset in the middle of a frame, then a fresh frame
        send(SYNC); send(8'h01);
        do_reset();
        send(SYNC); send(8'h00); send(8'h77); send(8'h77);
        idle(3);
        check_regs("after_reset");
        check("final_queue", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
